// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a registered-output synchronous FIFO into a valid/ready stream
// Ports:
//   clk          - clock, all state updates on the rising edge
//   reset        - synchronous active-high reset
//   fifo_empty   - upstream FIFO empty flag
//   fifo_rd_en   - upstream FIFO read strobe
//   fifo_rd_data - upstream FIFO read data, valid the cycle after an accepted read
//   m_valid      - stream valid
//   m_ready      - stream ready
//   m_data       - stream data
//   rd_count     - delivered-word counter, present only when FIFO_RD_COUNT_EN is defined
// Build option: define FIFO_RD_COUNT_EN to add the rd_count port and its counter.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_COUNT_EN
    ,
    output logic [15:0]           rd_count
`endif
);
    logic [DATA_WIDTH-1:0] head, tail;
    logic [1:0] occ, credit, wp;
    logic pend, transfer;
    // A read is allowed only if its word is guaranteed a slot when it lands a cycle later,
    // counting the word already in flight; a slot freed by this cycle's transfer counts.
    always_comb begin
        m_valid = !reset && occ != 2'd0;
        m_data = reset ? '0 : head;
        transfer = m_valid && m_ready;
        credit = occ + {1'b0, pend};
        fifo_rd_en = !reset && !fifo_empty && (credit < 2'd2 || (credit == 2'd2 && transfer));
        wp = occ - {1'b0, transfer};
    end
    // The landing word goes to the first free slot after the head has shifted out.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ <= 2'd0;
            pend <= 1'b0;
            head <= '0;
            tail <= '0;
        end else begin
            occ <= occ + {1'b0, pend} - {1'b0, transfer};
            pend <= fifo_rd_en;
            head <= (pend && wp == 2'd0) ? fifo_rd_data : transfer ? tail : head;
            tail <= (pend && wp == 2'd1) ? fifo_rd_data : tail;
        end
    end
`ifdef FIFO_RD_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            rd_count <= 16'd0;
        else if (transfer)
            rd_count <= rd_count + 16'd1;
    end
`endif
endmodule
